// File: rtl/num_toupper.sv
// num_toupper: registered 8-bit ASCII case converter with a valid/ready
// stream on each side and a saturating count of modified characters.
// Optional build macro: NUM_TOUPPER_LATIN1_EN adds ISO-8859-1 letter
// mapping (0xC0..0xFE except 0xD7, 0xDF, 0xF7). Without it every code
// 0x80..0xFF is a non-letter and passes unchanged.
module num_toupper #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_data_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_data_o,
  output logic             out_changed_o,
  input  logic             clr_count_i,
  output logic [CNT_W-1:0] conv_count_o
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } modeT;

  logic             outValid_q, outValid_d;
  logic [7:0]       outData_q, outData_d;
  logic             outChanged_q, outChanged_d;
  logic [CNT_W-1:0] convCount_q, convCount_d;

  logic       isLower;
  logic       isUpper;
  logic [7:0] mappedData;
  logic       mappedDiffers;
  logic       accept;
  modeT       modeSel;

  assign modeSel    = modeT'(mode_i);
  assign in_ready_o = !outValid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // Classify the incoming byte as a lowercase letter, an uppercase letter or neither
  always_comb begin
    isLower = (in_data_i >= 8'h61) && (in_data_i <= 8'h7A);
    isUpper = (in_data_i >= 8'h41) && (in_data_i <= 8'h5A);
`ifdef NUM_TOUPPER_LATIN1_EN
    if ((in_data_i >= 8'hE0) && (in_data_i <= 8'hFE) && (in_data_i != 8'hF7)) begin
      isLower = 1'b1;
    end
    if ((in_data_i >= 8'hC0) && (in_data_i <= 8'hDE) && (in_data_i != 8'hD7)) begin
      isUpper = 1'b1;
    end
`endif
  end

  // Apply the selected case rule; letters differ only in bit 5
  always_comb begin
    mappedData = in_data_i;
    unique case (modeSel)
      MODE_PASS:   mappedData = in_data_i;
      MODE_UPPER:  if (isLower) mappedData[5] = 1'b0;
      MODE_LOWER:  if (isUpper) mappedData[5] = 1'b1;
      MODE_TOGGLE: if (isLower || isUpper) mappedData[5] = ~in_data_i[5];
      default:     mappedData = in_data_i;
    endcase
    mappedDiffers = (mappedData != in_data_i);
  end

  // Next-state for the output register: load on accept, drop valid once drained
  always_comb begin
    outValid_d   = outValid_q;
    outData_d    = outData_q;
    outChanged_d = outChanged_q;
    if (accept) begin
      outValid_d   = 1'b1;
      outData_d    = mappedData;
      outChanged_d = mappedDiffers;
    end else if (outValid_q && out_ready_i) begin
      outValid_d = 1'b0;
    end
  end

  // Next-state for the counter: clear has priority, increments stop at all-ones
  always_comb begin
    convCount_d = convCount_q;
    if (clr_count_i) begin
      convCount_d = '0;
    end else if (accept && mappedDiffers && (convCount_q != {CNT_W{1'b1}})) begin
      convCount_d = convCount_q + 1'b1;
    end
  end

  // Output holding register; reset discards any pending byte at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outValid_q   <= 1'b0;
      outData_q    <= 8'h00;
      outChanged_q <= 1'b0;
    end else begin
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      outChanged_q <= outChanged_d;
    end
  end

  // Converted-character counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      convCount_q <= '0;
    end else begin
      convCount_q <= convCount_d;
    end
  end

  assign out_valid_o   = outValid_q;
  assign out_data_o    = outData_q;
  assign out_changed_o = outChanged_q;
  assign conv_count_o  = convCount_q;

endmodule

// File: tb/tb_num_toupper.sv
// Directed bench for num_toupper, built with CNT_W=4 so saturation is reachable.
// Expected values are hand-computed; Latin-1 expectations follow NUM_TOUPPER_LATIN1_EN.
module tb_num_toupper;

  localparam int CNT_W = 4;

`ifdef NUM_TOUPPER_LATIN1_EN
  localparam logic [7:0] EXP_E9    = 8'hC9;
  localparam logic       EXP_E9_CH = 1'b1;
  localparam int         LATIN_ADD = 1;
`else
  localparam logic [7:0] EXP_E9    = 8'hE9;
  localparam logic       EXP_E9_CH = 1'b0;
  localparam int         LATIN_ADD = 0;
`endif

  logic             clk;
  logic             rstN;
  logic             inValid;
  logic             inReady;
  logic [7:0]       inData;
  logic [1:0]       mode;
  logic             outValid;
  logic             outReady;
  logic [7:0]       outData;
  logic             outChanged;
  logic             clrCount;
  logic [CNT_W-1:0] convCount;

  int passCount  = 0;
  int checkCount = 0;

  num_toupper #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .in_data_i    (inData),
    .mode_i       (mode),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .out_data_o   (outData),
    .out_changed_o(outChanged),
    .clr_count_i  (clrCount),
    .conv_count_o (convCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] m,
                               input logic rdy, input logic clr);
    inValid  = v;
    inData   = d;
    mode     = m;
    outReady = rdy;
    clrCount = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic sendCheck(input string tag, input logic [7:0] d, input logic [1:0] m,
                           input logic [7:0] expData, input logic expCh);
    applyStimulus(1'b1, d, m, 1'b1, 1'b0);
    tick();
    checkOutput({tag, "_valid"}, {15'd0, outValid}, 16'd1);
    checkOutput({tag, "_data"}, {8'd0, outData}, {8'd0, expData});
    checkOutput({tag, "_changed"}, {15'd0, outChanged}, {15'd0, expCh});
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 2'b01, 1'b1, 1'b0);
    rstN = 1'b0;
    #12;
    checkOutput("rst_valid", {15'd0, outValid}, 16'd0);
    checkOutput("rst_data", {8'd0, outData}, 16'h0000);
    checkOutput("rst_changed", {15'd0, outChanged}, 16'd0);
    checkOutput("rst_count", {12'd0, convCount}, 16'd0);
    checkOutput("rst_in_ready", {15'd0, inReady}, 16'd1);
    @(negedge clk);
    rstN = 1'b1;
    tick();

    // Case boundaries in to-upper mode at full throughput
    sendCheck("b28", 8'h28, 2'b01, 8'h28, 1'b0);
    sendCheck("b61", 8'h61, 2'b01, 8'h41, 1'b1);
    sendCheck("b7A", 8'h7A, 2'b01, 8'h5A, 1'b1);
    sendCheck("b60", 8'h60, 2'b01, 8'h60, 1'b0);
    sendCheck("b7B", 8'h7B, 2'b01, 8'h7B, 1'b0);
    sendCheck("b48", 8'h48, 2'b01, 8'h48, 1'b0);
    checkOutput("bound_count", {12'd0, convCount}, 16'd2);
    applyStimulus(1'b0, 8'h00, 2'b01, 1'b1, 1'b0);
    tick();
    checkOutput("drain_valid", {15'd0, outValid}, 16'd0);
    checkOutput("drain_hold", {8'd0, outData}, 16'h0048);

    // Other modes
    sendCheck("m10", 8'h48, 2'b10, 8'h68, 1'b1);
    sendCheck("m11", 8'h67, 2'b11, 8'h47, 1'b1);
    sendCheck("m00", 8'h41, 2'b00, 8'h41, 1'b0);
    checkOutput("mode_count", {12'd0, convCount}, 16'd4);

    // High bytes
    sendCheck("hB7", 8'hB7, 2'b01, 8'hB7, 1'b0);
    sendCheck("hE9", 8'hE9, 2'b01, EXP_E9, EXP_E9_CH);
    sendCheck("hF7", 8'hF7, 2'b01, 8'hF7, 1'b0);
    checkOutput("high_count", {12'd0, convCount}, 16'(4 + LATIN_ADD));
    applyStimulus(1'b0, 8'h00, 2'b01, 1'b1, 1'b0);
    tick();

    // Backpressure
    applyStimulus(1'b1, 8'h61, 2'b01, 1'b0, 1'b0);
    tick();
    checkOutput("bp_data", {8'd0, outData}, 16'h0041);
    applyStimulus(1'b1, 8'h62, 2'b00, 1'b0, 1'b0);
    #1;
    checkOutput("bp_in_ready", {15'd0, inReady}, 16'd0);
    tick();
    checkOutput("bp_hold_valid", {15'd0, outValid}, 16'd1);
    checkOutput("bp_hold_data", {8'd0, outData}, 16'h0041);
    checkOutput("bp_hold_changed", {15'd0, outChanged}, 16'd1);
    checkOutput("bp_count", {12'd0, convCount}, 16'(5 + LATIN_ADD));
    applyStimulus(1'b1, 8'h62, 2'b01, 1'b1, 1'b0);
    #1;
    checkOutput("bp_release_ready", {15'd0, inReady}, 16'd1);
    tick();
    checkOutput("bp_next_data", {8'd0, outData}, 16'h0042);
    checkOutput("bp_next_count", {12'd0, convCount}, 16'(6 + LATIN_ADD));
    applyStimulus(1'b0, 8'h00, 2'b01, 1'b1, 1'b0);
    tick();
    checkOutput("bp_drain_valid", {15'd0, outValid}, 16'd0);

    // Counter saturation and clear priority
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h61 + 8'(i % 26), 2'b01, 1'b1, 1'b0);
      tick();
    end
    checkOutput("sat_count", {12'd0, convCount}, 16'd15);
    applyStimulus(1'b1, 8'h61, 2'b01, 1'b1, 1'b1);
    tick();
    checkOutput("clr_count", {12'd0, convCount}, 16'd0);
    checkOutput("clr_data", {8'd0, outData}, 16'h0041);

    // Asynchronous reset mid-stream
    applyStimulus(1'b1, 8'h62, 2'b01, 1'b1, 1'b0);
    tick();
    checkOutput("pre_rst_valid", {15'd0, outValid}, 16'd1);
    applyStimulus(1'b0, 8'h00, 2'b01, 1'b1, 1'b0);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {15'd0, outValid}, 16'd0);
    checkOutput("mid_rst_data", {8'd0, outData}, 16'h0000);
    checkOutput("mid_rst_count", {12'd0, convCount}, 16'd0);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    sendCheck("post_rst", 8'h7A, 2'b01, 8'h5A, 1'b1);
    checkOutput("post_rst_count", {12'd0, convCount}, 16'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/num_toupper.md
Name: num_toupper

Overview:
- Registered 8-bit ASCII case converter.
- Accepts one character per cycle on a valid/ready input stream and emits the case-mapped character one cycle later on a valid/ready output stream.
- Default mode converts lowercase letters to uppercase; other modes give passthrough, lowercase, or case toggle.
- Sits in the text datapath between byte source and sink; also keeps a saturating count of modified characters.

Parameters:
- CNT_W, 16, width of the converted-character counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input byte valid
- in_ready  output  1  block can accept input byte this cycle
- in_data  input  8  input character; bit 7 is MSB (legacy A), bit 0 is LSB (legacy H)
- mode  input  2  00 passthrough, 01 to-upper, 10 to-lower, 11 toggle case
- out_valid  output  1  output byte valid
- out_ready  input  1  sink accepts output byte
- out_data  output  8  converted character
- out_changed  output  1  out_data differs from the original input byte
- clr_count  input  1  synchronous clear of conv_count
- conv_count  output  CNT_W  number of accepted bytes that were modified; saturates at all-ones

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0x00, out_changed=0, conv_count=0.
  - in_ready reflects the reset state, i.e. 1.
- Letter classes:
  - lower = 0x61..0x7A.
  - upper = 0x41..0x5A.
  - All other codes, including 0x80..0xFF, are non-letters. Exception: see Optional Feature.
- Mapping, sampled with mode on the accept cycle:
  - 00: pass unchanged.
  - 01: lower -> clear bit 5; all else unchanged.
  - 10: upper -> set bit 5; all else unchanged.
  - 11: lower or upper -> invert bit 5; all else unchanged.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - On accept: out_data <= mapped byte, out_changed <= (mapped != in_data), out_valid <= 1.
  - When out_valid && out_ready with no new accept, out_valid <= 0 on the next edge; out_data holds its last value.
- Latency and throughput:
  - Latency is exactly 1 cycle from accept to out_valid.
  - Full throughput of one byte per cycle when out_ready is held high.
- Output stability: while out_valid && !out_ready, out_data and out_changed hold stable and in_ready=0.
- Counter:
  - conv_count increments on each accept whose mapped byte differs from its input.
  - Saturates at 2^CNT_W-1.
  - If clr_count and a counting accept occur in the same cycle, clear wins and the result is 0.
- mode changes take effect at the next accept and never alter an already-registered output.
- Reset asserted mid-transfer drops the pending output byte immediately (out_valid=0).

Optional Feature:
- Macro: NUM_TOUPPER_LATIN1_EN.
- When defined, ISO-8859-1 letters are also mapped:
  - Latin-1 lower = 0xE0..0xFE excluding 0xF7.
  - Latin-1 upper = 0xC0..0xDE excluding 0xD7.
  - Same bit-5 rules as ASCII letters, per mode.
  - 0xDF and 0xFF remain unchanged in all modes.
- When undefined, every code 0x80..0xFF is a non-letter and passes unchanged.

Test Plan:
- Case boundaries: mode=01, out_ready=1, send 0x28,0x61,0x7A,0x60,0x7B,0x48 -> out_data 0x28,0x41,0x5A,0x60,0x7B,0x48; out_changed 0,1,1,0,0,0; conv_count=2; each output appears 1 cycle after its accept.
- Other modes: send 0x48 in mode 10 -> 0x68; 0x67 in mode 11 -> 0x47; 0x41 in mode 00 -> 0x41 with out_changed=0.
- High bytes: mode=01, send 0xB7,0xE9,0xF7 -> without the macro 0xB7,0xE9,0xF7 unchanged; with NUM_TOUPPER_LATIN1_EN 0xB7,0xC9,0xF7.
- Backpressure: hold out_ready=0 after accepting 0x61 -> out_data stays 0x41, in_ready=0, a second byte 0x62 is not accepted; raise out_ready -> 0x62 is accepted that cycle and 0x42 follows.
- Counter: with CNT_W=4, send 20 lowercase bytes -> conv_count saturates at 15; clr_count asserted alongside a lowercase accept -> conv_count=0.
- Reset mid-stream: assert rst_n low asynchronously while out_valid=1 -> out_valid, out_data and conv_count go to 0 before the next clock edge; first accept after release behaves normally.
